// File: rtl/si_inst_fetch.sv
// Instruction fetch unit: REQ -> WAIT -> HOLD loop with PC redirect at the consumer handshake.
// Optional macro FETCH_MISALIGN_CHK_EN: a misaligned next PC sets sticky fetch_err_o and parks in ERR.
module si_inst_fetch #(
  parameter int unsigned          INST_DW  = 32,
  parameter int unsigned          INST_AW  = 32,
  parameter logic [INST_AW-1:0]   RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_o,
  output logic [INST_AW-1:0] imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INST_DW-1:0] imem_rdata_i,
  output logic [INST_DW-1:0] inst_o,
  output logic [INST_AW-1:0] inst_pc_o,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  input  logic               branch_en_i,
  input  logic [INST_AW-1:0] branch_offset_i,
  input  logic               jump_en_i,
  input  logic [INST_AW-1:0] jump_offset_i,
  input  logic               jalr_i,
  output logic               fetch_err_o
);

  typedef enum logic [2:0] {StRst, StReq, StWait, StHold, StErr} state_e;

  localparam logic [INST_AW-1:0] PcStep = INST_AW'(4);

  state_e             state_q, state_d;
  logic [INST_AW-1:0] pc_q, pc_d;
  logic               req_q, req_d;
  logic [INST_AW-1:0] addr_q, addr_d;
  logic [INST_DW-1:0] inst_q, inst_d;
  logic [INST_AW-1:0] inst_pc_q, inst_pc_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [INST_AW-1:0] target;
  logic [INST_AW-1:0] next_pc;
  logic               misaligned;

  // Redirect target; only consumed in the handshake cycle.
  always_comb begin
    if (jump_en_i && jalr_i) begin
      target = {jump_offset_i[INST_AW-1:1], 1'b0};
    end else if (jump_en_i) begin
      target = pc_q + jump_offset_i;
    end else if (branch_en_i) begin
      target = pc_q + branch_offset_i;
    end else begin
      target = pc_q + PcStep;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  assign next_pc    = target;
  assign misaligned = |target[1:0];
`else
  assign next_pc    = {target[INST_AW-1:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = 1'b0;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    err_d     = err_q;
    unique case (state_q)
      StRst: state_d = StReq;
      StReq: begin
        req_d   = 1'b1;
        addr_d  = pc_q;
        state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid_i) begin
          inst_d    = imem_rdata_i;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          state_d   = StHold;
        end
      end
      StHold: begin
        if (valid_q && inst_ready_i) begin
          valid_d = 1'b0;
          pc_d    = next_pc;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = StErr;
          end else begin
            state_d = StReq;
          end
        end
      end
      StErr: state_d = StErr;
      default: state_d = StRst;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StRst;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = valid_q;
  assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_si_inst_fetch.sv
// Self-checking bench for si_inst_fetch: directed cases then randomized redirects against a PC model.
// Honours FETCH_MISALIGN_CHK_EN the same way as the design build.
module tb_si_inst_fetch;

  localparam logic [31:0] ResetPc = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        branch_en_i;
  logic [31:0] branch_offset_i;
  logic        jump_en_i;
  logic [31:0] jump_offset_i;
  logic        jalr_i;
  logic        fetch_err_o;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 0;
  logic [31:0] exp_pc;
  logic        err_exp;

  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;

  si_inst_fetch #(
    .INST_DW  (32),
    .INST_AW  (32),
    .RESET_PC (ResetPc)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .branch_en_i     (branch_en_i),
    .branch_offset_i (branch_offset_i),
    .jump_en_i       (jump_en_i),
    .jump_offset_i   (jump_offset_i),
    .jalr_i          (jalr_i),
    .fetch_err_o     (fetch_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == ResetPc) return 32'h0000_0013;
    return {a[15:0] ^ 16'h5a3c, a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Instruction memory: one in-order reply mem_lat cycles after the request is seen.
  always @(posedge clk) begin
    if (!rst) begin
      imem_rvalid_i <= 1'b0;
      imem_rdata_i  <= '0;
      pend          <= 1'b0;
      pend_addr     <= '0;
      cnt           <= 0;
    end else begin
      imem_rvalid_i <= 1'b0;
      if (imem_req_o) begin
        if (mem_lat == 0) begin
          imem_rvalid_i <= 1'b1;
          imem_rdata_i  <= mem_word(imem_addr_o);
        end else begin
          pend      <= 1'b1;
          pend_addr <= imem_addr_o;
          cnt       <= mem_lat - 1;
        end
      end else if (pend) begin
        if (cnt == 0) begin
          imem_rvalid_i <= 1'b1;
          imem_rdata_i  <= mem_word(pend_addr);
          pend          <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_redirect();
    branch_en_i     = 1'b0;
    branch_offset_i = '0;
    jump_en_i       = 1'b0;
    jump_offset_i   = '0;
    jalr_i          = 1'b0;
  endtask

  // Step negedges until inst_valid_o, checking every request address against the model.
  task automatic wait_valid(output int lat, output int req_at);
    int seen;
    lat    = 0;
    req_at = -1;
    seen   = 0;
    while (!inst_valid_o && lat < 60) begin
      if (imem_req_o) begin
        check("req_addr", imem_addr_o, exp_pc);
        seen++;
        req_at = lat;
      end
      @(negedge clk);
      lat++;
    end
    check("valid_timeout", inst_valid_o, 1);
    check("req_count", seen, 1);
  endtask

  // Entered at a negedge with an instruction held; stalls, then handshakes with the redirect.
  task automatic accept(input logic b, input logic [31:0] bo, input logic j,
                        input logic [31:0] jo, input logic jl, input int stall);
    logic [31:0] t;
    check("hold_pc", inst_pc_o, exp_pc);
    check("hold_inst", inst_o, mem_word(exp_pc));
    for (int k = 0; k < stall; k++) begin
      inst_ready_i    = 1'b0;
      branch_en_i     = 1'($urandom);
      branch_offset_i = $urandom;
      jump_en_i       = 1'($urandom);
      jump_offset_i   = $urandom;
      jalr_i          = 1'($urandom);
      @(negedge clk);
      check("stall_inst", inst_o, mem_word(exp_pc));
      check("stall_pc", inst_pc_o, exp_pc);
      check("stall_req", imem_req_o, 0);
      check("stall_valid", inst_valid_o, 1);
    end
    inst_ready_i    = 1'b1;
    branch_en_i     = b;
    branch_offset_i = bo;
    jump_en_i       = j;
    jump_offset_i   = jo;
    jalr_i          = jl;
    @(negedge clk);
    inst_ready_i = 1'b0;
    clear_redirect();
    check("valid_drop", inst_valid_o, 0);
    if (j && jl)  t = jo & ~32'h1;
    else if (j)   t = exp_pc + jo;
    else if (b)   t = exp_pc + bo;
    else          t = exp_pc + 32'd4;
`ifdef FETCH_MISALIGN_CHK_EN
    if (t[1:0] != 2'b00) err_exp = 1'b1;
`else
    t = t & ~32'h3;
`endif
    exp_pc = t;
    check("fetch_err", fetch_err_o, err_exp);
  endtask

  task automatic accept_and_refetch(input logic b, input logic [31:0] bo, input logic j,
                                    input logic [31:0] jo, input logic jl, input int stall);
    int lat, req_at;
    accept(b, bo, j, jo, jl, stall);
    wait_valid(lat, req_at);
    if (mem_lat == 0) begin
      check("accept_to_valid", lat, 3);
      check("accept_to_req", req_at, 1);
    end
  endtask

  task automatic release_reset();
    int lat, req_at;
    exp_pc  = ResetPc;
    err_exp = 1'b0;
    mem_lat = 0;
    rst     = 1'b1;
    wait_valid(lat, req_at);
    check("release_req_cycle", req_at, 2);
    check("release_valid_cycle", lat, 4);
    check("first_inst", inst_o, 32'h0000_0013);
    check("first_pc", inst_pc_o, ResetPc);
  endtask

  task automatic check_reset_outputs();
    check("rst_req", imem_req_o, 0);
    check("rst_addr", imem_addr_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_pc", inst_pc_o, 0);
    check("rst_valid", inst_valid_o, 0);
    check("rst_err", fetch_err_o, 0);
  endtask

  initial begin
    logic [31:0] bo, jo;
    int          kind;
    rst          = 1'b0;
    inst_ready_i = 1'b0;
    clear_redirect();
    repeat (3) @(negedge clk);
    check_reset_outputs();

    release_reset();

    // Long stall, then plain sequential steps up to 0x8000_0010.
    accept_and_refetch(1'b0, '0, 1'b0, '0, 1'b0, 5);
    check("seq_pc", exp_pc, 32'h8000_0004);
    repeat (3) accept_and_refetch(1'b0, '0, 1'b0, '0, 1'b0, 0);
    check("reach_pc", inst_pc_o, 32'h8000_0010);

    // Backward branch, then jalr with branch also asserted (jump wins).
    accept_and_refetch(1'b1, 32'hffff_fff8, 1'b0, '0, 1'b0, 0);
    check("branch_pc", inst_pc_o, 32'h8000_0008);
    accept_and_refetch(1'b1, 32'h0000_0040, 1'b1, 32'h8000_0101, 1'b1, 1);
    check("jalr_pc", inst_pc_o, 32'h8000_0100);

    // Wrap at the top of the address space.
    accept_and_refetch(1'b0, '0, 1'b1, 32'hffff_fffd, 1'b1, 0);
    check("top_pc", inst_pc_o, 32'hffff_fffc);
    accept_and_refetch(1'b0, '0, 1'b0, '0, 1'b0, 0);
    check("wrap_pc", inst_pc_o, 32'h0000_0000);
    check("wrap_err", fetch_err_o, 0);

    for (int n = 0; n < 150; n++) begin
      mem_lat = $urandom_range(0, 3);
      kind    = $urandom_range(0, 3);
      bo      = (32'($urandom_range(0, 511)) - 32'd256) << 2;
      jo      = (32'($urandom_range(0, 511)) - 32'd256) << 2;
`ifndef FETCH_MISALIGN_CHK_EN
      bo = bo + 32'($urandom_range(0, 3));
      jo = jo + 32'($urandom_range(0, 3));
`endif
      if (kind == 3) begin
        jo = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
        jo[1] = 1'b0;
`endif
      end
      accept_and_refetch(kind == 1 || (kind >= 2 && $urandom_range(0, 1) == 1), bo,
                         kind >= 2, jo, kind == 3, $urandom_range(0, 3));
    end

    // Reset while a slow response is outstanding.
    mem_lat = 3;
    accept(1'b0, '0, 1'b0, '0, 1'b0, 0);
    for (int k = 0; k < 10 && !imem_req_o; k++) @(negedge clk);
    check("pre_rst_req", imem_req_o, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_reset_outputs();
    end
    release_reset();

    // Misaligned JAL from RESET_PC.
    mem_lat = 0;
`ifdef FETCH_MISALIGN_CHK_EN
    accept(1'b0, '0, 1'b1, 32'h0000_0006, 1'b0, 0);
    for (int k = 0; k < 10; k++) begin
      check("err_sticky", fetch_err_o, 1);
      check("err_no_req", imem_req_o, 0);
      check("err_no_valid", inst_valid_o, 0);
      @(negedge clk);
    end
`else
    accept_and_refetch(1'b0, '0, 1'b1, 32'h0000_0006, 1'b0, 0);
    check("misalign_pc", inst_pc_o, 32'h8000_0004);
    check("misalign_err", fetch_err_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
